// File: rtl/trace_render_pipe_if.sv
// vga_if: pixel timing and colour bundle shared along the VGA chain.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/trace_render_pipe.sv
// trace_render_pipe: oscilloscope trace, frame and grid overlay.
// Double-buffered sample RAM, vblank-shadowed settings, 3-cycle latency.
module trace_render_pipe #(
    parameter int NUM_CH = 2,
    parameter int DEPTH = 256,
    parameter int SAMPLE_W = 12,
    parameter int H_ORIGIN = 64,
    parameter int V_TOP = 100,
    parameter int WIN_W = 256,
    parameter int WIN_H = 256,
    parameter int GRID_STEP = 64,
    parameter logic [NUM_CH*12-1:0] CH_RGB = {12'hf0f, 12'haa0},
    parameter logic [11:0] FRAME_RGB = 12'hfa0,
    parameter logic [11:0] GRID_RGB = 12'h530,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_ch,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                wr_commit,
    input  logic signed [10:0]  x_offset,
    input  logic signed [10:0]  y_offset,
    input  logic [2:0]          scale_shift,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic                connect_mode,
    vga_if.in                   in,
    vga_if.out                  out
);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam logic [10:0] H_LO = 11'(H_ORIGIN);
    localparam logic [10:0] H_HI = 11'(H_ORIGIN + WIN_W - 1);
    localparam logic [10:0] V_LO = 11'(V_TOP);
    localparam logic [10:0] V_HI = 11'(V_TOP + WIN_H - 1);
    localparam logic [10:0] G_MASK = 11'(GRID_STEP - 1);
    localparam logic signed [12:0] ROW_MID = 13'(V_TOP + WIN_H / 2);
    localparam logic signed [SAMPLE_W:0] MID = {2'b01, {(SAMPLE_W-1){1'b0}}};

    logic                vblnk_q;
    logic                front;
    logic                pending;
    logic signed [10:0]  x_sh;
    logic signed [10:0]  y_sh;
    logic [2:0]          sh_sh;
    logic [NUM_CH-1:0]   en_sh;
    logic                conn_sh;
    logic                swap_evt;

    assign swap_evt = in.vblnk && !vblnk_q;
    assign wr_ready = !pending;

    // Settings and bank selection only move on the vblank rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            front   <= 1'b0;
            pending <= 1'b0;
            x_sh    <= '0;
            y_sh    <= '0;
            sh_sh   <= '0;
            en_sh   <= '0;
            conn_sh <= 1'b0;
        end else begin
            vblnk_q <= in.vblnk;
            if (swap_evt) begin
                x_sh    <= x_offset;
                y_sh    <= y_offset;
                sh_sh   <= scale_shift;
                en_sh   <= ch_enable;
                conn_sh <= connect_mode;
            end
            if (swap_evt && (pending || wr_commit)) begin
                front   <= !front;
                pending <= 1'b0;
            end else if (wr_commit) begin
                pending <= 1'b1;
            end
        end
    end

    logic [SAMPLE_W-1:0] mem [2][NUM_CH][DEPTH];
    logic [SAMPLE_W-1:0] rd_data [NUM_CH];

    logic [10:0]   hrel;
    logic [10:0]   vrel;
    logic          inwin0;
    logic          first0;
    logic          frame0;
    logic          grid0;
    logic [AW-1:0] col0;

    always_comb begin
        hrel   = in.hcount - H_LO;
        vrel   = in.vcount - V_LO;
        inwin0 = (in.hcount >= H_LO) && (in.hcount <= H_HI) &&
                 (in.vcount >= V_LO) && (in.vcount <= V_HI);
        col0   = AW'(hrel + $unsigned(x_sh));
        first0 = (in.hcount == H_LO);
        frame0 = inwin0 && ((in.hcount == H_LO) || (in.hcount == H_HI) ||
                            (in.vcount == V_LO) || (in.vcount == V_HI));
        grid0  = inwin0 && !frame0 &&
                 (((hrel & G_MASK) == '0) || ((vrel & G_MASK) == '0));
    end

    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready && (int'(wr_ch) < NUM_CH))
            mem[!front][wr_ch][wr_addr] <= wr_data;
        for (int c = 0; c < NUM_CH; c++)
            rd_data[c] <= mem[front][c][col0];
    end

    vga_t p1, p2, p3;
    logic win1, first1, frame1, grid1;
    logic win2, frame2, grid2;
    logic signed [SAMPLE_W:0] sdiff [NUM_CH];
    logic signed [SAMPLE_W:0] sscl  [NUM_CH];
    logic signed [12:0] row1     [NUM_CH];
    logic signed [12:0] prev1    [NUM_CH];
    logic signed [12:0] last_row [NUM_CH];
    logic signed [12:0] row2     [NUM_CH];
    logic signed [12:0] prev2    [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sdiff[c] = $signed({1'b0, rd_data[c]}) - MID;
            sscl[c]  = sdiff[c] >>> sh_sh;
            row1[c]  = ROW_MID - 13'(sscl[c]) - 13'(y_sh);
            prev1[c] = first1 ? row1[c] : last_row[c];
        end
    end

    logic signed [12:0] vs2;
    logic [NUM_CH-1:0]  hit;
    logic [11:0]        rgb2;

    always_comb begin
        vs2  = $signed({2'b00, p2.vcount});
        hit  = '0;
        rgb2 = p2.rgb;
        for (int c = 0; c < NUM_CH; c++) begin
            if (conn_sh)
                hit[c] = en_sh[c] && win2 &&
                         (vs2 >= ((row2[c] < prev2[c]) ? row2[c] : prev2[c])) &&
                         (vs2 <= ((row2[c] > prev2[c]) ? row2[c] : prev2[c]));
            else
                hit[c] = en_sh[c] && win2 && (vs2 == row2[c]);
        end
        if (grid2)
            rgb2 = GRID_RGB;
        if (frame2)
            rgb2 = FRAME_RGB;
        // Walk downwards so the lowest hitting channel wins
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (hit[c])
                rgb2 = CH_RGB[c*12 +: 12];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1     <= '0;
            p2     <= '0;
            p3     <= '0;
            win1   <= 1'b0;
            first1 <= 1'b0;
            frame1 <= 1'b0;
            grid1  <= 1'b0;
            win2   <= 1'b0;
            frame2 <= 1'b0;
            grid2  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                last_row[c] <= '0;
                row2[c]     <= '0;
                prev2[c]    <= '0;
            end
        end else begin
            p1 <= '{vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk,
                    hcount: in.hcount, hsync: in.hsync, hblnk: in.hblnk,
                    rgb: in.rgb};
            win1   <= inwin0;
            first1 <= first0;
            frame1 <= frame0;
            grid1  <= grid0;
            p2     <= p1;
            win2   <= win1;
            frame2 <= frame1;
            grid2  <= grid1;
            for (int c = 0; c < NUM_CH; c++) begin
                last_row[c] <= row1[c];
                row2[c]     <= row1[c];
                prev2[c]    <= prev1[c];
            end
            p3     <= p2;
            p3.rgb <= rgb2;
        end
    end

    assign out.vcount = p3.vcount;
    assign out.vsync  = p3.vsync;
    assign out.vblnk  = p3.vblnk;
    assign out.hcount = p3.hcount;
    assign out.hsync  = p3.hsync;
    assign out.hblnk  = p3.hblnk;
    assign out.rgb    = p3.rgb;

endmodule

// File: tb/tb_trace_render_pipe.sv
// tb_trace_render_pipe: random frames against a per-pixel reference model,
// plus hand-derived pixel checks for dot, connect, clip, priority and wrap.
module tb_trace_render_pipe;

    localparam int NUM_CH = 2;
    localparam int DEPTH = 16;
    localparam int HO = 8;
    localparam int VT = 4;
    localparam int WW = 32;
    localparam int WH = 32;
    localparam int GS = 8;
    localparam int HT = 48;
    localparam int VTOT = 40;
    localparam int K_RAND = 0, K_DOT = 1, K_CONN = 2, K_PRIO = 3, K_WRAP = 4;
    localparam logic [11:0] C0 = 12'hf0f;
    localparam logic [11:0] C1 = 12'haa0;
    localparam logic [11:0] FR = 12'hfa0;
    localparam logic [11:0] GR = 12'h530;

    typedef struct {
        int x;
        int y;
        int sh;
        int en;
        int conn;
    } cfg_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               wr_valid;
    logic               wr_ready;
    logic [0:0]         wr_ch;
    logic [3:0]         wr_addr;
    logic [11:0]        wr_data;
    logic               wr_commit;
    logic signed [10:0] x_offset;
    logic signed [10:0] y_offset;
    logic [2:0]         scale_shift;
    logic [1:0]         ch_enable;
    logic               connect_mode;

    vga_if vin();
    vga_if vout();

    trace_render_pipe #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .SAMPLE_W(12),
        .H_ORIGIN(HO), .V_TOP(VT), .WIN_W(WW), .WIN_H(WH),
        .GRID_STEP(GS), .CH_RGB({C1, C0}),
        .FRAME_RGB(FR), .GRID_RGB(GR)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit),
        .x_offset(x_offset), .y_offset(y_offset),
        .scale_shift(scale_shift), .ch_enable(ch_enable),
        .connect_mode(connect_mode),
        .in(vin), .out(vout)
    );

    int errors = 0;
    int checks = 0;
    int hits_seen = 0;

    int mmem [2][NUM_CH][DEPTH];
    int mfront, mx, my, msh, men, mconn;
    bit mpend, mvq;
    logic [36:0] expq [$];
    logic [11:0] img [VTOT][HT];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mfront = 0; mpend = 0; mvq = 0;
        mx = 0; my = 0; msh = 0; men = 0; mconn = 0;
        expq.delete();
        expq.push_back('0);
        expq.push_back('0);
    endtask

    function automatic int row_of(int c, int h);
        int a, s;
        a = (((h - HO + mx) % DEPTH) + DEPTH) % DEPTH;
        s = mmem[mfront][c][a] - 2048;
        return VT + WH / 2 - (s >>> msh) - my;
    endfunction

    function automatic logic [11:0] exp_rgb(int h, int v, logic [11:0] rin);
        int r, p, lo, hi;
        bit hit;
        if (!(h >= HO && h < HO + WW && v >= VT && v < VT + WH))
            return rin;
        for (int c = 0; c < NUM_CH; c++) begin
            if (((men >> c) & 1) == 1) begin
                r = row_of(c, h);
                p = (h == HO) ? r : row_of(c, h - 1);
                lo = (r < p) ? r : p;
                hi = (r < p) ? p : r;
                hit = (mconn != 0) ? (v >= lo && v <= hi) : (v == r);
                if (hit) begin
                    hits_seen++;
                    return (c == 0) ? C0 : C1;
                end
            end
        end
        if (h == HO || h == HO + WW - 1 || v == VT || v == VT + WH - 1)
            return FR;
        if (((h - HO) % GS) == 0 || ((v - VT) % GS) == 0)
            return GR;
        return rin;
    endfunction

    task automatic tick();
        logic [36:0] e, got;
        bit rise;
        @(posedge clk);
        if (!rst) begin
            e = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync,
                 vin.hblnk,
                 exp_rgb(int'(vin.hcount), int'(vin.vcount), vin.rgb)};
            expq.push_back(e);
            if (wr_valid && !mpend)
                mmem[1-mfront][int'(wr_ch)][int'(wr_addr)] = int'(wr_data);
            rise = vin.vblnk && !mvq;
            mvq = vin.vblnk;
            if (rise) begin
                mx = int'(x_offset);
                my = int'(y_offset);
                msh = int'(scale_shift);
                men = int'(ch_enable);
                mconn = int'(connect_mode);
            end
            if (rise && (mpend || wr_commit)) begin
                mfront = 1 - mfront;
                mpend = 0;
            end else if (wr_commit) begin
                mpend = 1;
            end
        end
        #1;
        got = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync,
               vout.hblnk, vout.rgb};
        if (rst) begin
            chk("rst_out", got, '0);
            chk("rst_ready", wr_ready, 1);
        end else begin
            chk("wr_ready", wr_ready, !mpend);
            if (expq.size() == 3)
                chk("pixel", got, expq.pop_front());
            if (vout.vcount < VTOT && vout.hcount < HT)
                img[vout.vcount][vout.hcount] = vout.rgb;
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.x = int'($urandom_range(0, 40)) - 20;
        c.y = int'($urandom_range(0, 12)) - 6;
        c.sh = int'($urandom_range(0, 3));
        c.en = int'($urandom_range(0, 3));
        c.conn = int'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic run_frame(input int kind, input cfg_t cfg, input int cc,
                             input int cm, input int rst_at);
        int plan [NUM_CH][DEPTH];
        int h, v;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int a = 0; a < DEPTH; a++) begin
                case (kind)
                    K_DOT:  plan[c][a] = (c == 0) ? 2048 :
                                         2028 + int'($urandom_range(0, 40));
                    K_CONN: plan[c][a] = (c == 0) ? ((a == 1) ? 2058 : 2048) : 0;
                    K_PRIO: plan[c][a] = 2048;
                    K_WRAP: plan[c][a] = (c == 0) ? 2048 + a : 2048;
                    default: plan[c][a] = 2028 + int'($urandom_range(0, 40));
                endcase
            end
        end
        for (int i = 0; i < HT * VTOT; i++) begin
            h = i % HT;
            v = i / HT;
            vin.hcount = 11'(h);
            vin.vcount = 11'(v);
            vin.hblnk = (h >= 44);
            vin.hsync = (h == 44 || h == 45);
            vin.vblnk = (v >= 38);
            vin.vsync = (v == 38);
            vin.rgb = 12'($urandom);
            rst = (rst_at >= 0 && i >= rst_at && i < rst_at + 3);
            if (rst)
                model_reset();
            wr_commit = (i == cm) && !rst;
            if (rst) begin
                wr_valid = 1'b0;
            end else if (i < NUM_CH * DEPTH) begin
                wr_valid = 1'b1;
                wr_ch = 1'(i / DEPTH);
                wr_addr = 4'(i % DEPTH);
                wr_data = 12'(plan[i / DEPTH][i % DEPTH]);
            end else if (cm >= 0 && i >= cm) begin
                wr_valid = ($urandom_range(0, 2) == 0);
                wr_ch = 1'($urandom);
                wr_addr = 4'($urandom);
                wr_data = 12'($urandom);
            end else begin
                wr_valid = 1'b0;
            end
            if (i == cc) begin
                x_offset = 11'(cfg.x);
                y_offset = 11'(cfg.y);
                scale_shift = 3'(cfg.sh);
                ch_enable = 2'(cfg.en);
                connect_mode = 1'(cfg.conn);
            end
            tick();
        end
    endtask

    initial begin
        int r, cm;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < NUM_CH; c++)
                for (int a = 0; a < DEPTH; a++)
                    mmem[b][c][a] = 0;
        wr_valid = 0; wr_ch = 0; wr_addr = 0; wr_data = 0; wr_commit = 0;
        x_offset = 0; y_offset = 0; scale_shift = 0; ch_enable = 0;
        connect_mode = 0;
        vin.hcount = 0; vin.vcount = 0; vin.hsync = 0; vin.vsync = 0;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = 0;
        rst = 1'b1;
        model_reset();
        repeat (4) tick();
        rst = 1'b0;

        run_frame(K_DOT, '{0, 0, 0, 1, 0}, 50, 500, -1);
        chk("no_trace_yet", img[VT+16][HO+5], GR);
        run_frame(K_CONN, '{0, 0, 0, 3, 1}, 50, 500, -1);
        chk("dot_a", img[VT+16][HO+5], C0);
        chk("dot_b", img[VT+16][HO+30], C0);
        run_frame(K_CONN, '{0, 0, 0, 1, 0}, 50, 500, -1);
        chk("conn_top", img[VT+6][HO+1], C0);
        chk("conn_mid", img[VT+8][HO+1], C0);
        chk("clip_frame", img[VT+WH-1][HO+3], FR);
        run_frame(K_PRIO, '{0, 0, 0, 3, 0}, 50, 500, -1);
        chk("dots_top", img[VT+6][HO+1], C0);
        chk("dots_gap", img[VT+8][HO+1], GR);
        run_frame(K_PRIO, '{0, 0, 0, 2, 0}, 50, 500, -1);
        chk("prio_ch0", img[VT+16][HO+8], C0);
        run_frame(K_PRIO, '{0, 0, 0, 0, 0}, 50, 500, -1);
        chk("prio_ch1", img[VT+16][HO+8], C1);
        run_frame(K_WRAP, '{-1, 0, 0, 1, 0}, 500, 900, -1);
        chk("prio_none", img[VT+16][HO+8], GR);
        run_frame(K_WRAP, '{0, 0, 0, 1, 0}, 300, 900, -1);
        chk("wrap", img[VT+1][HO], C0);
        chk("repeat", img[VT+1][HO+16], C0);
        run_frame(K_RAND, rand_cfg(), 50, 1824, -1);
        chk("x_new", img[VT+16][HO], C0);
        chk("x_old_gone", img[VT+1][HO], FR);
        run_frame(K_RAND, rand_cfg(), 50, -1, -1);
        for (int k = 0; k < 6; k++) begin
            r = int'($urandom_range(0, 3));
            cm = (r == 0) ? -1 : (r == 1) ? 1824 : int'($urandom_range(100, 1700));
            run_frame(K_RAND, rand_cfg(), int'($urandom_range(40, 1800)), cm,
                      (k == 2) ? 600 : -1);
        end
        chk("traces_seen", hits_seen > 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
